// File: rtl/window_comparator.sv
// Registered window comparator: classifies samples against a low/high window and
// reports a hysteresis- and debounce-filtered zone with change events.
module window_comparator #(
    parameter int unsigned N      = 8,
    parameter int unsigned SIGNED = 0,
    parameter int unsigned DEB    = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [N-1:0] sample,
    input  logic [N-1:0] thr_lo,
    input  logic [N-1:0] thr_hi,
    input  logic [N-1:0] hyst,
    output logic         out_valid,
    output logic         is_above,
    output logic         is_below,
    output logic         is_inside,
    output logic [1:0]   zone,
    output logic         zone_chg,
    output logic         cfg_err
);

    // Two guard bits keep threshold +/- hyst exact before saturation.
    localparam int unsigned W  = N + 2;
    localparam int unsigned CW = $clog2(DEB + 1);

    typedef logic signed [W-1:0] wide_t;

    typedef enum logic [1:0] {
        ZONE_INSIDE = 2'b00,
        ZONE_BELOW  = 2'b01,
        ZONE_ABOVE  = 2'b10
    } zone_e;

    localparam wide_t TYPE_MAX = (SIGNED != 0) ? wide_t'({3'b000, {(N-1){1'b1}}})
                                               : wide_t'({2'b00, {N{1'b1}}});
    localparam wide_t TYPE_MIN = (SIGNED != 0) ? wide_t'({3'b111, {(N-1){1'b0}}})
                                               : wide_t'(0);

    // Map an N-bit value into the common signed compare domain.
    function automatic wide_t ext(input logic [N-1:0] v);
        if (SIGNED != 0) begin
            return wide_t'({{2{v[N-1]}}, v});
        end else begin
            return wide_t'({2'b00, v});
        end
    endfunction

    logic          out_valid_q, out_valid_d;
    logic          is_above_q, is_above_d;
    logic          is_below_q, is_below_d;
    logic          is_inside_q, is_inside_d;
    logic          zone_chg_q, zone_chg_d;
    logic          cfg_err_q, cfg_err_d;
    zone_e         zone_q, zone_d;
    zone_e         pend_q, pend_d;
    logic [CW-1:0] cnt_q, cnt_d;

    wide_t         s_w, lo_w, hi_w;
    wide_t         hi_raw, lo_raw, hi_exit, lo_exit;
    logic          above_c, below_c;
    zone_e         cand_c;
    logic [CW-1:0] cnt_n;

    // Compare domain, saturated exit thresholds and candidate zone.
    always_comb begin
        s_w     = ext(sample);
        lo_w    = ext(thr_lo);
        hi_w    = ext(thr_hi);
        hi_raw  = hi_w - wide_t'({2'b00, hyst});
        lo_raw  = lo_w + wide_t'({2'b00, hyst});
        hi_exit = (hi_raw < TYPE_MIN) ? TYPE_MIN : hi_raw;
        lo_exit = (lo_raw > TYPE_MAX) ? TYPE_MAX : lo_raw;
        above_c = (s_w > hi_w);
        below_c = (s_w < lo_w);
        cand_c  = zone_q;
        case (zone_q)
            ZONE_INSIDE: begin
                if (above_c)      cand_c = ZONE_ABOVE;
                else if (below_c) cand_c = ZONE_BELOW;
                else              cand_c = ZONE_INSIDE;
            end
            ZONE_ABOVE: begin
                if (below_c)              cand_c = ZONE_BELOW;
                else if (s_w < hi_exit)   cand_c = ZONE_INSIDE;
                else                      cand_c = ZONE_ABOVE;
            end
            ZONE_BELOW: begin
                if (above_c)              cand_c = ZONE_ABOVE;
                else if (s_w > lo_exit)   cand_c = ZONE_INSIDE;
                else                      cand_c = ZONE_BELOW;
            end
            default: cand_c = ZONE_INSIDE;
        endcase
    end

    // Next-state: raw flags, config check and debounce.
    always_comb begin
        out_valid_d = in_valid;
        is_above_d  = is_above_q;
        is_below_d  = is_below_q;
        is_inside_d = is_inside_q;
        zone_chg_d  = 1'b0;
        cfg_err_d   = (lo_w > hi_w);
        zone_d      = zone_q;
        pend_d      = pend_q;
        cnt_d       = cnt_q;
        cnt_n       = cnt_q;

        if (in_valid) begin
            is_above_d  = above_c;
            is_below_d  = ~above_c & below_c;
            is_inside_d = ~above_c & ~below_c;
        end

        if (cfg_err_q) begin
            cnt_d = '0;
        end else if (in_valid) begin
            if (cand_c == zone_q) begin
                cnt_n = '0;
            end else if (cand_c == pend_q) begin
                cnt_n = cnt_q + CW'(1);
            end else begin
                pend_d = cand_c;
                cnt_n  = CW'(1);
            end
            if (cnt_n == CW'(DEB)) begin
                zone_d     = pend_d;
                cnt_d      = '0;
                zone_chg_d = 1'b1;
            end else begin
                cnt_d = cnt_n;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            is_above_q  <= 1'b0;
            is_below_q  <= 1'b0;
            is_inside_q <= 1'b0;
            zone_chg_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
            zone_q      <= ZONE_INSIDE;
            pend_q      <= ZONE_INSIDE;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            is_above_q  <= is_above_d;
            is_below_q  <= is_below_d;
            is_inside_q <= is_inside_d;
            zone_chg_q  <= zone_chg_d;
            cfg_err_q   <= cfg_err_d;
            zone_q      <= zone_d;
            pend_q      <= pend_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign is_above  = is_above_q;
    assign is_below  = is_below_q;
    assign is_inside = is_inside_q;
    assign zone      = zone_q;
    assign zone_chg  = zone_chg_q;
    assign cfg_err   = cfg_err_q;

endmodule
